// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared IO register map, status bit positions and region select for mem_io_bridge.
package mem_io_pkg;
  localparam logic [17:0] IO_RXTX_A = 18'h30000;
  localparam logic [17:0] IO_STAT_A = 18'h30004;
  localparam logic [17:0] IO_CNT_A = 18'h30008;
  localparam logic [1:0] IO_SEL = 2'b11;
  localparam int STAT_RXNE = 0;
  localparam int STAT_TXFULL = 1;
  localparam int STAT_RXOVF = 2;
  localparam int STAT_TXOVF = 3;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: power-of-2 byte FIFO; pushes are judged against full before the edge, pops against empty.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [7:0] mem [DEPTH];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // storage is not reset, so mask the head while empty to present 0x00
  assign dout = empty ? 8'h00 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes CPU byte accesses to sync RAM or IO (TX/RX FIFOs, status), 1-cycle read return.
// Define MEM_IO_BRIDGE_CYCLE_CNT_EN to add a 32-bit cycle counter at 0x30008..0x3000B.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int RAM_AW = 17,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_a,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_wn,
  output logic [7:0]        cpu_rn,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_wn,
  input  logic [7:0]        ram_rn,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid
);
  logic io_sel, hit_rxtx, hit_stat, first, tx_push, rx_pop, stat_rd;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_ovf, sel_q, prev_v, prev_wr;
  logic [31:0] prev_a;
  logic [7:0] io_rd, io_rd_q, rx_head, stat, cnt_rd;
  assign io_sel = cpu_a[17:16] == IO_SEL;
  assign hit_rxtx = io_sel && cpu_a[17:0] == IO_RXTX_A;
  assign hit_stat = io_sel && cpu_a[17:0] == IO_STAT_A;
  assign first = !cpu_wr && (!prev_v || prev_wr || prev_a != cpu_a);
  assign tx_push = hit_rxtx && cpu_wr;
  assign rx_pop = hit_rxtx && first;
  assign stat_rd = hit_stat && first;
  assign ram_a = cpu_a[RAM_AW-1:0];
  assign ram_wn = cpu_wn;
  assign ram_wr = cpu_wr && !io_sel;
  assign cpu_rn = sel_q ? io_rd_q : ram_rn;
  assign tx_valid = !tx_empty;
  always_comb begin
    stat = 8'h00;
    stat[STAT_RXNE] = !rx_empty;
    stat[STAT_TXFULL] = tx_full;
    stat[STAT_RXOVF] = rx_ovf;
    stat[STAT_TXOVF] = tx_ovf;
  end
  // a held RXTX read keeps returning the byte popped on its first cycle
  assign io_rd = hit_rxtx ? (first ? rx_head : io_rd_q) : hit_stat ? stat : cnt_rd;
`ifdef MEM_IO_BRIDGE_CYCLE_CNT_EN
  logic [31:0] cnt, shadow;
  logic hit_cnt;
  assign hit_cnt = io_sel && cpu_a[17:2] == IO_CNT_A[17:2];
  // byte 0 is read live in the same cycle the shadow snapshots, so all 4 bytes agree
  assign cnt_rd = !hit_cnt ? 8'h00 : cpu_a[1:0] == 2'd0 ? cnt[7:0] : shadow[8*cpu_a[1:0] +: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      shadow <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (hit_cnt && cpu_a[1:0] == 2'd0 && first) shadow <= cnt;
    end
`else
  assign cnt_rd = 8'h00;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_q <= 1'b0;
      io_rd_q <= 8'h00;
      prev_v <= 1'b0;
      prev_wr <= 1'b0;
      prev_a <= '0;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      sel_q <= io_sel;
      io_rd_q <= io_rd;
      prev_v <= 1'b1;
      prev_wr <= cpu_wr;
      prev_a <= cpu_a;
      tx_ovf <= (tx_push && tx_full) || (tx_ovf && !stat_rd);
      rx_ovf <= (rx_valid && rx_full) || (rx_ovf && !stat_rd);
    end
  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_valid && tx_ready),
    .din(cpu_wn), .dout(tx_data), .full(tx_full), .empty(tx_empty)
  );
  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop),
    .din(rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: vector table plus read-return scoreboard for mem_io_bridge with a small RAM model.
module tb_mem_io_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] cpu_a = '0;
  logic cpu_wr = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0] cpu_wn = '0, rx_data = '0, ram_rn = '0;
  logic [7:0] cpu_rn, ram_wn, tx_data;
  logic [16:0] ram_a;
  logic ram_wr, tx_valid;
  logic [7:0] ram [512];
  int checks = 0, errors = 0;
  localparam logic [31:0] IDLE = 32'h123, RXTX = 32'h30000, STAT = 32'h30004;
  typedef struct {
    logic [31:0] a; logic wr; logic [7:0] wn;
    logic rxv; logic [7:0] rxd; logic txr;
    logic crn; logic [7:0] ern;
    logic ctx; logic etv; logic [7:0] etd;
    logic erw;
  } vec_t;
  typedef struct { logic chk; logic [7:0] exp; } sb_t;
  vec_t vecs[$];
  sb_t sb[$];
  mem_io_bridge dut (
    .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_wn(cpu_wn), .cpu_rn(cpu_rn),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_wn(ram_wn), .ram_rn(ram_rn),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[8:0]] <= ram_wn;
    ram_rn <= ram[ram_a[8:0]];
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %h want %h", n, $time, act, exp);
    end
  endtask
  function automatic vec_t v(input logic [31:0] a, input logic wr, input logic [7:0] wn,
                             input logic rxv, input logic [7:0] rxd, input logic txr,
                             input logic crn, input logic [7:0] ern,
                             input logic ctx, input logic etv, input logic [7:0] etd, input logic erw);
    vec_t t;
    t.a = a; t.wr = wr; t.wn = wn; t.rxv = rxv; t.rxd = rxd; t.txr = txr;
    t.crn = crn; t.ern = ern; t.ctx = ctx; t.etv = etv; t.etd = etd; t.erw = erw;
    return t;
  endfunction
  task automatic apply(input vec_t t);
    sb_t e;
    cpu_a = t.a; cpu_wr = t.wr; cpu_wn = t.wn;
    rx_valid = t.rxv; rx_data = t.rxd; tx_ready = t.txr;
    sb.push_back('{t.crn, t.ern});
    #1;
    chk("ram_wr", {31'b0, ram_wr}, {31'b0, t.erw});
    chk("ram_a", {15'b0, ram_a}, {15'b0, t.a[16:0]});
    if (t.ctx) begin
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, t.etv});
      if (t.etv) chk("tx_data", {24'b0, tx_data}, {24'b0, t.etd});
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.chk) chk("cpu_rn", {24'b0, cpu_rn}, {24'b0, e.exp});
    @(negedge clk);
  endtask
  task automatic run_all;
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    foreach (ram[i]) ram[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rn", {24'b0, cpu_rn}, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    rst = 1'b0;
    vecs.push_back(v(IDLE, 1, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(IDLE, 0, 0, 0, 0, 0, 1, 8'h5A, 0, 0, 0, 0));
    vecs.push_back(v(32'h30001, 1, 8'h77, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(32'h3000C, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0));
`ifndef MEM_IO_BRIDGE_CYCLE_CNT_EN
    vecs.push_back(v(32'h30008, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0));
`endif
    for (int i = 0; i < 3; i++) vecs.push_back(v(RXTX, 1, 8'h41 + 8'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(IDLE, 0, 0, 0, 0, 0, 1, 8'h5A, 1, 1, 8'h41, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(IDLE, 0, 0, 0, 0, 1, 1, 8'h5A, 1, 1, 8'h41 + 8'(i), 0));
    vecs.push_back(v(IDLE, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    run_all();
    for (int i = 0; i < 17; i++) vecs.push_back(v(RXTX, 1, 8'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(STAT, 0, 0, 0, 0, 0, 1, 8'h0A, 0, 0, 0, 0));
    vecs.push_back(v(IDLE, 0, 0, 0, 0, 0, 1, 8'h5A, 0, 0, 0, 0));
    vecs.push_back(v(STAT, 0, 0, 0, 0, 0, 1, 8'h02, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) vecs.push_back(v(IDLE, 0, 0, 0, 0, 1, 0, 0, 1, 1, 8'(i), 0));
    vecs.push_back(v(IDLE, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    run_all();
    vecs.push_back(v(IDLE, 0, 0, 1, 8'h10, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(IDLE, 0, 0, 1, 8'h20, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(RXTX, 0, 0, 0, 0, 0, 1, 8'h10, 0, 0, 0, 0));
    vecs.push_back(v(IDLE, 0, 0, 0, 0, 0, 1, 8'h5A, 0, 0, 0, 0));
    vecs.push_back(v(RXTX, 0, 0, 0, 0, 0, 1, 8'h20, 0, 0, 0, 0));
    vecs.push_back(v(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(RXTX, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0));
    run_all();
    for (int i = 0; i < 16; i++) vecs.push_back(v(IDLE, 0, 0, 1, 8'h80 + 8'(i), 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(RXTX, 0, 0, 1, 8'hFF, 0, 1, 8'h80, 0, 0, 0, 0));
    vecs.push_back(v(STAT, 0, 0, 0, 0, 0, 1, 8'h05, 0, 0, 0, 0));
    for (int i = 1; i < 16; i++) begin
      vecs.push_back(v(RXTX, 0, 0, 0, 0, 0, 1, 8'h80 + 8'(i), 0, 0, 0, 0));
      vecs.push_back(v(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    vecs.push_back(v(RXTX, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0));
    vecs.push_back(v(STAT, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(RXTX, 1, 8'hC0 + 8'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(IDLE, 0, 0, 0, 0, 1, 0, 0, 1, 1, 8'hC0, 0));
    run_all();
    cpu_a = IDLE; tx_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("arst_tx_data", {24'b0, tx_data}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    vecs.push_back(v(32'h80030004, 0, 0, 0, 0, 1, 1, 8'h00, 1, 0, 0, 0));
    vecs.push_back(v(IDLE, 0, 0, 0, 0, 1, 1, 8'h5A, 1, 0, 0, 0));
    run_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
